// File: rtl/reservation_station_if.sv
`default_nettype none
//============================================================================
// Module   : reservation_station_if
// Brief    : Bundle of the reservation station's allocation, broadcast and
//            issue signals. The master side is the ROB/ALU environment, the
//            slave side is the reservation station itself.
// Revision : 1.0 - initial release
//============================================================================
interface reservation_station_if #(
    parameter int TAG_W = 3
);
    // allocation from the reorder buffer
    logic [4:0]       op_in;
    logic [31:0]      value1_in;
    logic [31:0]      value2_in;
    logic [TAG_W-1:0] query1_in;
    logic [TAG_W-1:0] query2_in;
    logic [TAG_W-1:0] target_in;
    logic [31:0]      imm_in;
    logic             flush;
    // result broadcasts
    logic [TAG_W-1:0] alu_num;
    logic [31:0]      alu_value;
    logic [TAG_W-1:0] mem_num;
    logic [31:0]      mem_value;
    // issue handshake towards the ALU
    logic             alu_ready;
    logic             rs_full;
    logic             issue_valid;
    logic [4:0]       issue_op;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [31:0]      issue_imm;
    logic [TAG_W-1:0] issue_tag;

    modport master (
        output op_in, value1_in, value2_in, query1_in, query2_in, target_in,
               imm_in, flush, alu_num, alu_value, mem_num, mem_value, alu_ready,
        input  rs_full, issue_valid, issue_op, issue_a, issue_b, issue_imm,
               issue_tag
    );

    modport slave (
        input  op_in, value1_in, value2_in, query1_in, query2_in, target_in,
               imm_in, flush, alu_num, alu_value, mem_num, mem_value, alu_ready,
        output rs_full, issue_valid, issue_op, issue_a, issue_b, issue_imm,
               issue_tag
    );
endinterface
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
//============================================================================
// Module   : reservation_station
// Brief    : Issue buffer between the ROB and the ALU. Holds instructions
//            until both operands are known (capturing them from the ALU and
//            memory broadcasts) and issues one ready entry per cycle through
//            a registered valid/ready handshake.
// Options  : RS_OLDEST_FIRST_EN - oldest eligible entry wins selection
//            (4-bit saturating age per slot); otherwise lowest index wins.
// Revision : 1.0 - initial release
//============================================================================
module reservation_station #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    reservation_station_if.slave bus
);

    localparam int         c_IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [4:0] c_OP_NONE = 5'b11111;

    // slot storage
    logic [ENTRIES-1:0] r_valid;
    logic [4:0]         r_op  [ENTRIES];
    logic [31:0]        r_v1  [ENTRIES];
    logic [31:0]        r_v2  [ENTRIES];
    logic [31:0]        r_imm [ENTRIES];
    logic [TAG_W-1:0]   r_q1  [ENTRIES];
    logic [TAG_W-1:0]   r_q2  [ENTRIES];
    logic [TAG_W-1:0]   r_tag [ENTRIES];
`ifdef RS_OLDEST_FIRST_EN
    logic [3:0]         r_age [ENTRIES];
    logic [3:0]         w_best_age;
`endif

    // issue register
    logic               r_issue_valid;
    logic [4:0]         r_issue_op;
    logic [31:0]        r_issue_a;
    logic [31:0]        r_issue_b;
    logic [31:0]        r_issue_imm;
    logic [TAG_W-1:0]   r_issue_tag;

    logic [ENTRIES-1:0] w_eligible;
    logic               w_sel_found;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [c_IDX_W-1:0] w_alloc_idx;
    logic               w_full;
    logic               w_alloc;
    logic               w_issue_load;

    // A pending tag is satisfied by a broadcast carrying the same non-zero tag.
    function automatic logic f_hit(input logic [TAG_W-1:0] q,
                                   input logic [TAG_W-1:0] alu_n,
                                   input logic [TAG_W-1:0] mem_n);
        return (q != '0) && ((q == alu_n) || (q == mem_n));
    endfunction

    // Value to capture on a hit; the ALU broadcast wins a tag collision.
    function automatic logic [31:0] f_wake(input logic [TAG_W-1:0] q,
                                           input logic [31:0]      v,
                                           input logic [TAG_W-1:0] alu_n,
                                           input logic [31:0]      alu_v,
                                           input logic [TAG_W-1:0] mem_n,
                                           input logic [31:0]      mem_v);
        if ((q != '0) && (q == alu_n)) begin
            return alu_v;
        end else if ((q != '0) && (q == mem_n)) begin
            return mem_v;
        end
        return v;
    endfunction

    assign w_full       = &r_valid;
    assign w_alloc      = (bus.op_in != c_OP_NONE) && !w_full;
    assign w_issue_load = !r_issue_valid || bus.alu_ready;

    // Entries with both operands resolved, judged on pre-edge state.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_eligible[i] = r_valid[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
        end
    end

    // Pick the winning eligible entry (oldest or lowest index).
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
        w_best_age  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_eligible[i] && (!w_sel_found || (r_age[i] > w_best_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = i[c_IDX_W-1:0];
                w_best_age  = r_age[i];
            end
        end
`else
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_eligible[i] && !w_sel_found) begin
                w_sel_found = 1'b1;
                w_sel_idx   = i[c_IDX_W-1:0];
            end
        end
`endif
    end

    // Lowest-index free slot; slots freed by this edge's issue are still valid here.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_alloc_idx = i[c_IDX_W-1:0];
            end
        end
    end

    // Slot wakeup, issue-register load and allocation with broadcast bypass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_op    <= c_OP_NONE;
            r_issue_a     <= '0;
            r_issue_b     <= '0;
            r_issue_imm   <= '0;
            r_issue_tag   <= '0;
`ifdef RS_OLDEST_FIRST_EN
            for (int i = 0; i < ENTRIES; i++) begin
                r_age[i] <= '0;
            end
`endif
        end else if (bus.flush) begin
            r_valid       <= '0;
            r_issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (r_valid[i]) begin
                    if (f_hit(r_q1[i], bus.alu_num, bus.mem_num)) begin
                        r_v1[i] <= f_wake(r_q1[i], r_v1[i], bus.alu_num, bus.alu_value,
                                          bus.mem_num, bus.mem_value);
                        r_q1[i] <= '0;
                    end
                    if (f_hit(r_q2[i], bus.alu_num, bus.mem_num)) begin
                        r_v2[i] <= f_wake(r_q2[i], r_v2[i], bus.alu_num, bus.alu_value,
                                          bus.mem_num, bus.mem_value);
                        r_q2[i] <= '0;
                    end
`ifdef RS_OLDEST_FIRST_EN
                    if (r_age[i] != 4'hF) begin
                        r_age[i] <= r_age[i] + 4'd1;
                    end
`endif
                end
            end

            if (w_issue_load) begin
                r_issue_valid <= w_sel_found;
                if (w_sel_found) begin
                    r_issue_op           <= r_op[w_sel_idx];
                    r_issue_a            <= r_v1[w_sel_idx];
                    r_issue_b            <= r_v2[w_sel_idx];
                    r_issue_imm          <= r_imm[w_sel_idx];
                    r_issue_tag          <= r_tag[w_sel_idx];
                    r_valid[w_sel_idx]   <= 1'b0;
                end
            end

            if (w_alloc) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_op[w_alloc_idx]    <= bus.op_in;
                r_imm[w_alloc_idx]   <= bus.imm_in;
                r_tag[w_alloc_idx]   <= bus.target_in;
                r_v1[w_alloc_idx]    <= f_wake(bus.query1_in, bus.value1_in, bus.alu_num,
                                               bus.alu_value, bus.mem_num, bus.mem_value);
                r_v2[w_alloc_idx]    <= f_wake(bus.query2_in, bus.value2_in, bus.alu_num,
                                               bus.alu_value, bus.mem_num, bus.mem_value);
                r_q1[w_alloc_idx]    <= f_hit(bus.query1_in, bus.alu_num, bus.mem_num)
                                        ? '0 : bus.query1_in;
                r_q2[w_alloc_idx]    <= f_hit(bus.query2_in, bus.alu_num, bus.mem_num)
                                        ? '0 : bus.query2_in;
`ifdef RS_OLDEST_FIRST_EN
                r_age[w_alloc_idx]   <= '0;
`endif
            end
        end
    end

    assign bus.rs_full     = w_full;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_op    = r_issue_op;
    assign bus.issue_a     = r_issue_a;
    assign bus.issue_b     = r_issue_b;
    assign bus.issue_imm   = r_issue_imm;
    assign bus.issue_tag   = r_issue_tag;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
//============================================================================
// Module   : tb_reservation_station
// Brief    : Self-checking bench for reservation_station: directed scenarios
//            followed by randomized traffic against a slot-level reference
//            model. Honours RS_OLDEST_FIRST_EN for the selection rule.
// Revision : 1.0 - initial release
//============================================================================
module tb_reservation_station;

    localparam int         ENTRIES   = 4;
    localparam int         TAG_W     = 3;
    localparam logic [4:0] c_OP_NONE = 5'b11111;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reservation_station_if #(.TAG_W(TAG_W)) rs_bus ();

    reservation_station #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rs_bus.slave)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        logic [4:0]  op;
        logic [31:0] v1, v2, imm;
        logic [2:0]  q1, q2, tag;
        int          age;
    } slot_t;

    slot_t       m_slot [ENTRIES];
    bit          m_iv;
    logic [4:0]  m_iop;
    logic [31:0] m_ia, m_ib, m_iimm;
    logic [2:0]  m_itag;

    function automatic void resolve(input logic [2:0] q_i, input logic [31:0] v_i,
                                    output logic [2:0] q_o, output logic [31:0] v_o);
        q_o = q_i;
        v_o = v_i;
        if (q_i != 0 && q_i == rs_bus.alu_num) begin
            q_o = 0; v_o = rs_bus.alu_value;
        end else if (q_i != 0 && q_i == rs_bus.mem_num) begin
            q_o = 0; v_o = rs_bus.mem_value;
        end
    endfunction

    function automatic int count_valid();
        int n = 0;
        foreach (m_slot[i]) if (m_slot[i].valid) n++;
        return n;
    endfunction

    // advance the model by one clock edge using the inputs now on the bus
    task automatic model_edge();
        slot_t nxt [ENTRIES];
        int    cand[$];
        int    win;
        int    nvalid;
        nxt = m_slot;
        if (!rst) begin
            foreach (nxt[i]) begin nxt[i].valid = 0; nxt[i].age = 0; end
            m_iv = 0; m_iop = c_OP_NONE; m_ia = 0; m_ib = 0; m_iimm = 0; m_itag = 0;
            m_slot = nxt;
            return;
        end
        if (rs_bus.flush) begin
            foreach (nxt[i]) nxt[i].valid = 0;
            m_iv = 0;
            m_slot = nxt;
            return;
        end
        nvalid = count_valid();
        foreach (m_slot[i])
            if (m_slot[i].valid && m_slot[i].q1 == 0 && m_slot[i].q2 == 0) cand.push_back(i);
        foreach (m_slot[i]) begin
            if (m_slot[i].valid) begin
                resolve(m_slot[i].q1, m_slot[i].v1, nxt[i].q1, nxt[i].v1);
                resolve(m_slot[i].q2, m_slot[i].v2, nxt[i].q2, nxt[i].v2);
                nxt[i].age = (m_slot[i].age < 15) ? m_slot[i].age + 1 : 15;
            end
        end
        if (!m_iv || rs_bus.alu_ready) begin
            if (cand.size() == 0) begin
                m_iv = 0;
            end else begin
                win = cand[0];
`ifdef RS_OLDEST_FIRST_EN
                foreach (cand[k]) if (m_slot[cand[k]].age > m_slot[win].age) win = cand[k];
`endif
                m_iv = 1;
                m_iop = m_slot[win].op; m_ia = m_slot[win].v1; m_ib = m_slot[win].v2;
                m_iimm = m_slot[win].imm; m_itag = m_slot[win].tag;
                nxt[win].valid = 0;
            end
        end
        if (rs_bus.op_in != c_OP_NONE && nvalid < ENTRIES) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (!m_slot[i].valid) begin
                    nxt[i].valid = 1;
                    nxt[i].op = rs_bus.op_in;
                    nxt[i].imm = rs_bus.imm_in;
                    nxt[i].tag = rs_bus.target_in;
                    nxt[i].age = 0;
                    resolve(rs_bus.query1_in, rs_bus.value1_in, nxt[i].q1, nxt[i].v1);
                    resolve(rs_bus.query2_in, rs_bus.value2_in, nxt[i].q2, nxt[i].v2);
                    break;
                end
            end
        end
        m_slot = nxt;
    endtask

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_model();
        check_value("rs_full", rs_bus.rs_full, count_valid() == ENTRIES);
        check_value("issue_valid", rs_bus.issue_valid, m_iv);
        if (m_iv) begin
            check_value("issue_op", rs_bus.issue_op, m_iop);
            check_value("issue_a", rs_bus.issue_a, m_ia);
            check_value("issue_b", rs_bus.issue_b, m_ib);
            check_value("issue_imm", rs_bus.issue_imm, m_iimm);
            check_value("issue_tag", rs_bus.issue_tag, m_itag);
        end
    endtask

    // one clock: model sees the same inputs the DUT samples, outputs checked 1ns later
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rs_bus.op_in = c_OP_NONE;
        rs_bus.value1_in = 0; rs_bus.value2_in = 0;
        rs_bus.query1_in = 0; rs_bus.query2_in = 0;
        rs_bus.target_in = 0; rs_bus.imm_in = 0;
        rs_bus.alu_num = 0; rs_bus.alu_value = 0;
        rs_bus.mem_num = 0; rs_bus.mem_value = 0;
        rs_bus.flush = 0;
    endtask

    task automatic set_alloc(input logic [4:0] op, input logic [31:0] v1, input logic [2:0] q1,
                             input logic [31:0] v2, input logic [2:0] q2,
                             input logic [2:0] target, input logic [31:0] imm);
        set_idle();
        rs_bus.op_in = op;
        rs_bus.value1_in = v1; rs_bus.query1_in = q1;
        rs_bus.value2_in = v2; rs_bus.query2_in = q2;
        rs_bus.target_in = target; rs_bus.imm_in = imm;
    endtask

    localparam logic [2:0] c_OLDEST_EXP_TAG =
`ifdef RS_OLDEST_FIRST_EN
        3'd2;
`else
        3'd3;
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        foreach (m_slot[i]) begin m_slot[i] = '{default: 0}; end
        m_iv = 0; m_iop = c_OP_NONE; m_ia = 0; m_ib = 0; m_iimm = 0; m_itag = 0;
        rst = 1'b0;
        set_idle();
        rs_bus.alu_ready = 1'b1;

        // reset state
        step(); step();
        check_value("rst_issue_valid", rs_bus.issue_valid, 0);
        check_value("rst_issue_op", rs_bus.issue_op, 5'h1F);
        check_value("rst_issue_a", rs_bus.issue_a, 0);
        check_value("rst_issue_b", rs_bus.issue_b, 0);
        check_value("rst_issue_imm", rs_bus.issue_imm, 0);
        check_value("rst_issue_tag", rs_bus.issue_tag, 0);
        check_value("rst_rs_full", rs_bus.rs_full, 0);
        rst = 1'b1;
        step();

        // simple issue
        set_alloc(5'h01, 32'd5, 0, 32'd7, 0, 3'd3, 32'h11);
        step();
        check_value("simple_not_yet", rs_bus.issue_valid, 0);
        set_idle();
        step();
        check_value("simple_valid", rs_bus.issue_valid, 1);
        check_value("simple_a", rs_bus.issue_a, 5);
        check_value("simple_b", rs_bus.issue_b, 7);
        check_value("simple_tag", rs_bus.issue_tag, 3);
        step();
        check_value("simple_one_cycle", rs_bus.issue_valid, 0);

        // dependency wakeup
        set_alloc(5'h02, 32'd0, 3'd2, 32'd1, 0, 3'd4, 0);
        step();
        set_idle();
        step();
        check_value("dep_waiting", rs_bus.issue_valid, 0);
        rs_bus.alu_num = 3'd2; rs_bus.alu_value = 32'd10;
        step();
        set_idle();
        step();
        check_value("dep_valid", rs_bus.issue_valid, 1);
        check_value("dep_a", rs_bus.issue_a, 10);
        check_value("dep_b", rs_bus.issue_b, 1);

        // broadcast collision: ALU value wins
        set_alloc(5'h03, 32'd0, 3'd4, 32'd2, 0, 3'd5, 0);
        step();
        set_idle();
        rs_bus.alu_num = 3'd4; rs_bus.alu_value = 32'hAA;
        rs_bus.mem_num = 3'd4; rs_bus.mem_value = 32'hBB;
        step();
        set_idle();
        step();
        check_value("collide_a", rs_bus.issue_a, 32'hAA);

        // full and stall
        step();
        rs_bus.alu_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            set_alloc(5'h04, 32'(k * 16), 0, 32'(k), 0, 3'(k), 32'(k));
            step();
        end
        check_value("full_after_fill", rs_bus.rs_full, 1);
        set_idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check_value("stall_hold_tag", rs_bus.issue_tag, 1);
            check_value("stall_hold_a", rs_bus.issue_a, 16);
        end
        rs_bus.alu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_value("no_ignored_tag", rs_bus.issue_valid && rs_bus.issue_tag == 3'd6, 0);
        end

        // flush with entries pending and a held issue
        rs_bus.alu_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_alloc(5'h05, 32'(k), 0, 32'(k), 0, 3'(k), 0);
            step();
        end
        check_value("pre_flush_valid", rs_bus.issue_valid, 1);
        set_idle();
        rs_bus.flush = 1'b1;
        step();
        check_value("flush_valid", rs_bus.issue_valid, 0);
        check_value("flush_full", rs_bus.rs_full, 0);
        rs_bus.flush = 1'b0;
        rs_bus.alu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_value("post_flush_quiet", rs_bus.issue_valid, 0);
        end

        // same with reset
        rs_bus.alu_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_alloc(5'h06, 32'(k), 0, 32'(k), 0, 3'(k), 0);
            step();
        end
        set_idle();
        rst = 1'b0;
        step();
        check_value("reset_valid", rs_bus.issue_valid, 0);
        check_value("reset_op", rs_bus.issue_op, 5'h1F);
        check_value("reset_full", rs_bus.rs_full, 0);
        rst = 1'b1;
        rs_bus.alu_ready = 1'b1;
        step();

        // selection order: older waiting A in slot 1 vs younger ready B in slot 0
        set_alloc(5'h07, 0, 3'd6, 32'd1, 0, 3'd1, 0);   // X -> slot 0
        step();
        set_alloc(5'h08, 0, 3'd5, 32'd2, 0, 3'd2, 0);   // A -> slot 1
        step();
        set_idle();
        rs_bus.alu_num = 3'd6; rs_bus.alu_value = 32'h60;
        step();
        set_idle();
        step();                                          // X issues, slot 0 freed
        set_alloc(5'h09, 32'd3, 0, 32'd3, 0, 3'd3, 0);   // B -> slot 0
        rs_bus.alu_num = 3'd5; rs_bus.alu_value = 32'h50;
        step();
        set_idle();
        step();
        check_value("select_order_tag", rs_bus.issue_tag, c_OLDEST_EXP_TAG);
        step(); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            if ($urandom_range(0, 9) >= 4) begin
                rs_bus.op_in     = 5'($urandom_range(0, 30));
                rs_bus.value1_in = $urandom;
                rs_bus.value2_in = $urandom;
                rs_bus.query1_in = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                rs_bus.query2_in = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                rs_bus.target_in = 3'($urandom_range(0, 7));
                rs_bus.imm_in    = $urandom;
            end
            rs_bus.alu_num   = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rs_bus.alu_value = $urandom;
            rs_bus.mem_num   = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rs_bus.mem_value = $urandom;
            rs_bus.alu_ready = ($urandom_range(0, 3) != 0);
            rs_bus.flush     = ($urandom_range(0, 99) == 0);
            rst              = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
